// File: rtl/station_scheduler_pkg.sv
// Shared constants for the reservation-station scheduler: station count,
// 64-bit uOp packing and hazard-kind flag positions.
package station_scheduler_pkg;

   localparam int NST_DEFAULT = 4;
   localparam int UOP_W       = 64;

   // uOp packing, MSB first: pc | k16 | agu_k16 | fn | flags | adr | mem
   localparam int UOP_PC_LSB    = 48;
   localparam int UOP_K16_LSB   = 32;
   localparam int UOP_AGUK_LSB  = 16;
   localparam int UOP_FN_LSB    = 12;
   localparam int UOP_FLAGS_LSB = 8;
   localparam int UOP_ADR_LSB   = 4;
   localparam int UOP_MEM_LSB   = 0;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] k16;
      logic [15:0] agu_k16;
      logic [3:0]  fn;
      logic [3:0]  flags;
      logic [3:0]  adr;
      logic [3:0]  mem;
   } uop_t;

   localparam int HZ_RAW = 0;
   localparam int HZ_WAR = 1;
   localparam int HZ_WAW = 2;
   localparam int HZ_MEM = 3;
   localparam int HZ_N   = 4;

   typedef logic [HZ_N-1:0] hz_flags_t;

endpackage

// File: rtl/station_hazard.sv
// Pairwise dependency check: does an older station (old_*) block the
// candidate station (cand_*) from issuing?
module station_hazard
   import station_scheduler_pkg::*;
(
   input  logic [3:0] cand_d_adr,
   input  logic [2:0] cand_a_adr,
   input  logic [2:0] cand_b_adr,
   input  logic       cand_ld_mem,
   input  logic       cand_st_mem,
   input  logic [3:0] old_lock_wr,
   input  logic [2:0] old_lock_rd0,
   input  logic [2:0] old_lock_rd1,
   input  logic [2:0] old_lock_rd2,
   input  logic       old_lock_loads,
   output logic       hazard
);

   hz_flags_t kind;
   logic      cand_wr;
   logic      old_wr;

   assign cand_wr = cand_d_adr[3];
   assign old_wr  = old_lock_wr[3];

   always_comb begin
      kind         = '0;
      kind[HZ_RAW] = old_wr && ((old_lock_wr[2:0] == cand_a_adr) ||
                                (old_lock_wr[2:0] == cand_b_adr));
      kind[HZ_WAR] = cand_wr && ((cand_d_adr[2:0] == old_lock_rd0) ||
                                 (cand_d_adr[2:0] == old_lock_rd1) ||
                                 (cand_d_adr[2:0] == old_lock_rd2));
      kind[HZ_WAW] = cand_wr && old_wr && (cand_d_adr[2:0] == old_lock_wr[2:0]);
      kind[HZ_MEM] = (cand_ld_mem || cand_st_mem) && old_lock_loads;
   end

   assign hazard = |kind;

endmodule

// File: rtl/station_scheduler.sv
// In-order allocation to a ring of reservation stations and oldest-first,
// hazard-aware issue into a single registered execution slot.
module station_scheduler
   import station_scheduler_pkg::*;
#(
   parameter int NST = NST_DEFAULT
)
(
   input  logic                     clk,
   input  logic                     a_rst,
   input  logic                     dec_valid,
   output logic                     dec_ready,
   output logic [NST-1:0]           st_feed,
   input  logic [NST-1:0]           st_complete,
   input  logic [NST-1:0]           st_ready,
   input  logic [4*NST-1:0]         st_d_adr,
   input  logic [3*NST-1:0]         st_a_adr,
   input  logic [3*NST-1:0]         st_b_adr,
   input  logic [4*NST-1:0]         st_lock_wr,
   input  logic [3*NST-1:0]         st_lock_rd0,
   input  logic [3*NST-1:0]         st_lock_rd1,
   input  logic [3*NST-1:0]         st_lock_rd2,
   input  logic [NST-1:0]           st_lock_loads,
   input  logic [NST-1:0]           st_ld_mem,
   input  logic [NST-1:0]           st_st_mem,
   input  logic [UOP_W*NST-1:0]     st_uop,
   output logic [NST-1:0]           sched_ack,
   output logic                     exe_valid,
   output logic [UOP_W-1:0]         exe_uop,
   output logic [$clog2(NST)-1:0]   exe_slot,
   input  logic                     exe_ready
);

   localparam int SW = $clog2(NST);
   localparam int CW = $clog2(NST + 1);

   logic [SW-1:0]      head;
   logic [SW-1:0]      tail;
   logic [CW-1:0]      count;
   logic               alloc;
   logic               retire;

   logic [SW-1:0]      age [NST];
   logic [NST-1:0]     occupied;
   logic [NST-1:0]     blocked;
   logic [NST-1:0]     eligible;
   logic [NST*NST-1:0] haz;

   logic               sel_valid;
   logic [SW-1:0]      sel;
   logic [SW-1:0]      idx;
   logic               issue;
   logic [UOP_W-1:0]   uop_arr [NST];

   logic               exe_valid_q;
   uop_t               exe_uop_q;
   logic [SW-1:0]      exe_slot_q;

   // ------------------------------------------------------------------
   // Allocation / retirement ring
   // ------------------------------------------------------------------
   assign dec_ready = (count < CW'(NST));
   assign alloc     = dec_valid && dec_ready && a_rst;
   assign retire    = (count != '0) && st_complete[head];
   assign st_feed   = alloc ? (NST'(1) << tail) : '0;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (alloc)
            tail <= tail + SW'(1);
         if (retire)
            head <= head + SW'(1);
         case ({alloc, retire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Age is distance from head; the power-of-two ring makes the
   // subtraction wrap naturally, so age order survives pointer wrap.
   always_comb begin
      for (int i = 0; i < NST; i++) begin
         age[i]      = SW'(i) - head;
         occupied[i] = CW'(age[i]) < count;
      end
   end

   // ------------------------------------------------------------------
   // Pairwise hazards: haz[i*NST+j] = older j blocks candidate i
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NST; gi++) begin : g_cand
      assign uop_arr[gi] = st_uop[gi*UOP_W +: UOP_W];
      for (genvar gj = 0; gj < NST; gj++) begin : g_old
         if (gi == gj) begin : g_self
            assign haz[gi*NST+gj] = 1'b0;
         end else begin : g_pair
            station_hazard u_hz (
               .cand_d_adr     (st_d_adr[gi*4 +: 4]),
               .cand_a_adr     (st_a_adr[gi*3 +: 3]),
               .cand_b_adr     (st_b_adr[gi*3 +: 3]),
               .cand_ld_mem    (st_ld_mem[gi]),
               .cand_st_mem    (st_st_mem[gi]),
               .old_lock_wr    (st_lock_wr[gj*4 +: 4]),
               .old_lock_rd0   (st_lock_rd0[gj*3 +: 3]),
               .old_lock_rd1   (st_lock_rd1[gj*3 +: 3]),
               .old_lock_rd2   (st_lock_rd2[gj*3 +: 3]),
               .old_lock_loads (st_lock_loads[gj]),
               .hazard         (haz[gi*NST+gj])
            );
         end
      end
   end

   always_comb begin
      blocked  = '0;
      eligible = '0;
      for (int i = 0; i < NST; i++) begin
         for (int j = 0; j < NST; j++) begin
            if ((j != i) && (age[j] < age[i]) && occupied[j] &&
                !st_complete[j] && haz[i*NST+j])
               blocked[i] = 1'b1;
         end
         eligible[i] = occupied[i] && st_ready[i] && !blocked[i];
      end
   end

   // Walk from youngest to oldest so the oldest eligible station wins.
   always_comb begin
      sel_valid = 1'b0;
      sel       = head;
      idx       = head;
      for (int k = NST - 1; k >= 0; k--) begin
         idx = head + SW'(k);
         if (eligible[idx]) begin
            sel_valid = 1'b1;
            sel       = idx;
         end
      end
   end

   // ------------------------------------------------------------------
   // Issue register
   // ------------------------------------------------------------------
   assign issue     = sel_valid && (!exe_valid_q || exe_ready);
   assign sched_ack = issue ? (NST'(1) << sel) : '0;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         exe_valid_q <= 1'b0;
         exe_uop_q   <= '0;
         exe_slot_q  <= '0;
      end else if (issue) begin
         exe_valid_q <= 1'b1;
         exe_uop_q   <= uop_t'(uop_arr[sel]);
         exe_slot_q  <= sel;
      end else if (exe_ready) begin
         exe_valid_q <= 1'b0;
      end
   end

   assign exe_valid = exe_valid_q;
   assign exe_uop   = exe_uop_q;
   assign exe_slot  = exe_slot_q;

endmodule

// File: tb/tb_station_scheduler.sv
// Directed and randomized checks of station_scheduler against an age-ordered
// queue model of the station ring and the issue register.
module tb_station_scheduler;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              a_rst = 1'b0;
   logic              dec_valid = 1'b0;
   logic              dec_ready;
   logic [N-1:0]      st_feed;
   logic [N-1:0]      st_complete = '0;
   logic [N-1:0]      st_ready = '0;
   logic [4*N-1:0]    st_d_adr = '0;
   logic [3*N-1:0]    st_a_adr = '0;
   logic [3*N-1:0]    st_b_adr = '0;
   logic [4*N-1:0]    st_lock_wr = '0;
   logic [3*N-1:0]    st_lock_rd0 = '0;
   logic [3*N-1:0]    st_lock_rd1 = '0;
   logic [3*N-1:0]    st_lock_rd2 = '0;
   logic [N-1:0]      st_lock_loads = '0;
   logic [N-1:0]      st_ld_mem = '0;
   logic [N-1:0]      st_st_mem = '0;
   logic [64*N-1:0]   st_uop = '0;
   logic [N-1:0]      sched_ack;
   logic              exe_valid;
   logic [63:0]       exe_uop;
   logic [1:0]        exe_slot;
   logic              exe_ready = 1'b0;

   always #5 clk = ~clk;

   station_scheduler #(.NST(N)) dut (
      .clk           (clk),
      .a_rst         (a_rst),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .st_feed       (st_feed),
      .st_complete   (st_complete),
      .st_ready      (st_ready),
      .st_d_adr      (st_d_adr),
      .st_a_adr      (st_a_adr),
      .st_b_adr      (st_b_adr),
      .st_lock_wr    (st_lock_wr),
      .st_lock_rd0   (st_lock_rd0),
      .st_lock_rd1   (st_lock_rd1),
      .st_lock_rd2   (st_lock_rd2),
      .st_lock_loads (st_lock_loads),
      .st_ld_mem     (st_ld_mem),
      .st_st_mem     (st_st_mem),
      .st_uop        (st_uop),
      .sched_ack     (sched_ack),
      .exe_valid     (exe_valid),
      .exe_uop       (exe_uop),
      .exe_slot      (exe_slot),
      .exe_ready     (exe_ready)
   );

   int checks   = 0;
   int failures = 0;

   // station-side stimulus state
   bit         comp [N];
   bit         rdy  [N];
   logic [3:0] dadr [N];
   logic [2:0] aa   [N];
   logic [2:0] ba   [N];
   logic [3:0] lwr  [N];
   logic [2:0] lr0  [N];
   logic [2:0] lr1  [N];
   logic [2:0] lr2  [N];
   bit         ll   [N];
   bit         ldm  [N];
   bit         stm  [N];
   logic [63:0] uop [N];
   bit         rand_fields = 1'b0;

   // reference model: allocated slots oldest-first, next slot, issue register
   int          q[$];
   int          tail_m;
   bit          ev;
   int          es;
   logic [63:0] eu;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit hz(int i, int j);
      bit raw, war, waw, mem;
      raw = lwr[j][3] && (lwr[j][2:0] == aa[i] || lwr[j][2:0] == ba[i]);
      war = dadr[i][3] && (dadr[i][2:0] == lr0[j] || dadr[i][2:0] == lr1[j] ||
                           dadr[i][2:0] == lr2[j]);
      waw = dadr[i][3] && lwr[j][3] && (dadr[i][2:0] == lwr[j][2:0]);
      mem = (ldm[i] || stm[i]) && ll[j];
      return raw || war || waw || mem;
   endfunction

   function automatic int oldest_eligible();
      for (int k = 0; k < q.size(); k++) begin
         int i;
         bit blk;
         i = q[k];
         blk = 1'b0;
         for (int m = 0; m < k; m++)
            if (!comp[q[m]] && hz(i, q[m])) blk = 1'b1;
         if (rdy[i] && !blk) return i;
      end
      return -1;
   endfunction

   task automatic clear_stations();
      for (int s = 0; s < N; s++) begin
         comp[s] = 1'b1; rdy[s] = 1'b0;
         dadr[s] = '0; aa[s] = '0; ba[s] = '0; lwr[s] = '0;
         lr0[s] = '0; lr1[s] = '0; lr2[s] = '0;
         ll[s] = 1'b0; ldm[s] = 1'b0; stm[s] = 1'b0;
         uop[s] = {16'hA000 + 16'(s), 48'h0};
      end
      q.delete();
      tail_m = 0;
      ev = 1'b0;
   endtask

   task automatic randomize_fields(input int s);
      dadr[s] = 4'($urandom);
      aa[s]   = 3'($urandom);
      ba[s]   = 3'($urandom);
      lwr[s]  = 4'($urandom);
      lr0[s]  = 3'($urandom);
      lr1[s]  = 3'($urandom);
      lr2[s]  = 3'($urandom);
      ll[s]   = ($urandom_range(0, 3) == 0);
      ldm[s]  = ($urandom_range(0, 3) == 0);
      stm[s]  = ($urandom_range(0, 3) == 0);
      uop[s]  = {$urandom, $urandom};
   endtask

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         st_complete[s]        = comp[s];
         st_ready[s]           = rdy[s];
         st_d_adr[4*s +: 4]    = dadr[s];
         st_a_adr[3*s +: 3]    = aa[s];
         st_b_adr[3*s +: 3]    = ba[s];
         st_lock_wr[4*s +: 4]  = lwr[s];
         st_lock_rd0[3*s +: 3] = lr0[s];
         st_lock_rd1[3*s +: 3] = lr1[s];
         st_lock_rd2[3*s +: 3] = lr2[s];
         st_lock_loads[s]      = ll[s];
         st_ld_mem[s]          = ldm[s];
         st_st_mem[s]          = stm[s];
         st_uop[64*s +: 64]    = uop[s];
      end
   endtask

   task automatic step(input bit dv, input bit er);
      bit exp_dr, alloc, issue, ret;
      int sel;
      @(negedge clk);
      dec_valid = dv;
      exe_ready = er;
      drive();
      #1;
      exp_dr = (q.size() < N);
      alloc  = dv && exp_dr;
      sel    = oldest_eligible();
      issue  = (sel >= 0) && (!ev || er);
      chk("dec_ready", 64'(dec_ready), 64'(exp_dr));
      chk("st_feed", 64'(st_feed), alloc ? (64'd1 << tail_m) : 64'd0);
      chk("sched_ack", 64'(sched_ack), issue ? (64'd1 << sel) : 64'd0);
      chk("exe_valid", 64'(exe_valid), 64'(ev));
      if (ev) begin
         chk("exe_slot", 64'(exe_slot), 64'(es));
         chk("exe_uop", exe_uop, eu);
      end
      ret = (q.size() > 0) && comp[q[0]];
      @(posedge clk);
      if (ret) void'(q.pop_front());
      if (alloc) begin
         q.push_back(tail_m);
         comp[tail_m] = 1'b0;
         rdy[tail_m]  = 1'b0;
         if (rand_fields) randomize_fields(tail_m);
         tail_m = (tail_m + 1) % N;
      end
      if (issue) begin
         ev = 1'b1; es = sel; eu = uop[sel]; rdy[sel] = 1'b0;
      end else if (er) begin
         ev = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      dec_valid = 1'b1;
      a_rst = 1'b0;
      clear_stations();
      drive();
      #1;
      chk("rst_exe_valid", 64'(exe_valid), 64'd0);
      chk("rst_exe_uop", exe_uop, 64'd0);
      chk("rst_exe_slot", 64'(exe_slot), 64'd0);
      chk("rst_dec_ready", 64'(dec_ready), 64'd1);
      chk("rst_st_feed", 64'(st_feed), 64'd0);
      chk("rst_sched_ack", 64'(sched_ack), 64'd0);
      @(negedge clk);
      dec_valid = 1'b0;
      a_rst = 1'b1;
   endtask

   initial begin
      // fill from reset, then RAW ordering between slot0 and slot1
      do_reset();
      repeat (5) step(1'b1, 1'b1);
      lwr[0] = 4'b1010; aa[1] = 3'b010;
      rdy[0] = 1'b1;    rdy[1] = 1'b1;
      repeat (3) step(1'b0, 1'b1);
      comp[0] = 1'b1;
      repeat (3) step(1'b0, 1'b1);

      // independent younger station issues past a non-ready older one
      do_reset();
      repeat (2) step(1'b1, 1'b1);
      rdy[1] = 1'b1;
      step(1'b0, 1'b1);
      // backpressure holds the issued uOp and suppresses acks
      rdy[0] = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1);

      // wrapped ring: slot0 load waits behind slot3 load lock
      do_reset();
      repeat (4) step(1'b1, 1'b1);
      comp[0] = 1'b1; comp[1] = 1'b1; comp[2] = 1'b1;
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      ll[3] = 1'b1; ldm[0] = 1'b1; rdy[0] = 1'b1;
      repeat (2) step(1'b0, 1'b1);
      comp[3] = 1'b1;
      repeat (3) step(1'b0, 1'b1);

      // asynchronous reset while an issue is held
      do_reset();
      repeat (4) step(1'b1, 1'b1);
      rdy[2] = 1'b1;
      step(1'b0, 1'b1);
      @(negedge clk);
      dec_valid = 1'b1;
      exe_ready = 1'b0;
      drive();
      #1;
      chk("pre_rst_exe_valid", 64'(exe_valid), 64'd1);
      chk("pre_rst_dec_ready", 64'(dec_ready), 64'd0);
      a_rst = 1'b0;
      #1;
      chk("async_exe_valid", 64'(exe_valid), 64'd0);
      chk("async_dec_ready", 64'(dec_ready), 64'd1);
      chk("async_st_feed", 64'(st_feed), 64'd0);
      chk("async_sched_ack", 64'(sched_ack), 64'd0);
      clear_stations();
      @(negedge clk);
      dec_valid = 1'b0;
      a_rst = 1'b1;

      // randomized traffic
      do_reset();
      rand_fields = 1'b1;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < q.size(); k++) begin
            int s;
            s = q[k];
            if (!comp[s]) begin
               if ($urandom_range(0, 2) == 0) rdy[s] = ($urandom_range(0, 1) == 1);
               if ($urandom_range(0, 6) == 0) begin
                  comp[s] = 1'b1;
                  rdy[s]  = 1'b0;
               end
            end
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/station_scheduler.md
STATION_SCHEDULER -- requirements
Module: station_scheduler

Interface
REQ-001 Parameter NST, default 4: number of reservation stations served; fixed power of two.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 a_rst  in  1  reset, asynchronous, active-low.
REQ-004 dec_valid  in  1  decoder offers a uOp for allocation.
REQ-005 dec_ready  out  1  a free station exists; allocation occurs when dec_valid & dec_ready.
REQ-006 st_feed  out  NST  one-hot feed strobe to the allocated station.
REQ-007 st_complete  in  NST  per-station id_complete (1 = station idle).
REQ-008 st_ready  in  NST  per-station r_ready.
REQ-009 st_d_adr  in  4*NST  per-station destination, bit 3 = write enable.
REQ-010 st_a_adr, st_b_adr  in  3*NST each  per-station source registers.
REQ-011 st_lock_wr  in  4*NST  per-station terminal write lock, bit 3 = valid.
REQ-012 st_lock_rd0, st_lock_rd1, st_lock_rd2  in  3*NST each  per-station terminal read locks.
REQ-013 st_lock_loads, st_ld_mem, st_st_mem  in  NST each  per-station memory-order flags.
REQ-014 st_uop  in  64*NST  per-station packed issue fields (pc, k16, agu_k16, fn, flags, adr, mem controls).
REQ-015 sched_ack  out  NST  one-hot acknowledge to the issued station.
REQ-016 exe_valid  out  1  issue register holds a uOp.
REQ-017 exe_uop  out  64  registered fields of the issued uOp.
REQ-018 exe_slot  out  log2(NST)  index of the issued station.
REQ-019 exe_ready  in  1  execution stage accepts exe_uop this cycle.

Function
REQ-020 Allocation SHALL be in order: tail pointer names next station; occupancy count 0..NST; dec_ready = (count < NST).
REQ-021 On allocation st_feed[tail]=1 for that cycle only; tail increments modulo NST.
REQ-022 Retirement: when count>0 and st_complete[head]=1 and head was allocated at least one cycle earlier, head increments modulo NST, count decrements; at most one retirement per cycle.
REQ-023 Simultaneous allocate and retire SHALL leave count unchanged; allocate when full SHALL NOT occur even if retire coincides (dec_ready uses registered count).
REQ-024 Candidate i is eligible when occupied, st_ready[i]=1, and no hazard against any occupied older station j (head..i-1, not complete).
REQ-025 Hazards: RAW lock_wr[j] valid and equal to a_adr[i] or b_adr[i]; WAR d_adr[i][3] and d_adr[i][2:0] equal to any lock_rd of j; WAW both write valid with equal address; memory: (ld_mem[i] or st_mem[i]) and lock_loads[j].
REQ-026 The oldest eligible station SHALL be selected; at most one issue per cycle.
REQ-027 Issue occurs when a station is selected and (exe_valid=0 or exe_ready=1); then sched_ack[sel]=1 combinationally and exe_uop/exe_slot load next edge, exe_valid=1.
REQ-028 exe_ready=1 with no selection SHALL clear exe_valid; exe_ready=0 with exe_valid=1 SHALL hold exe_uop and drive sched_ack=0.
REQ-029 Issue latency: ready in cycle N -> exe_valid in cycle N+1.
REQ-030 Pointer wrap from NST-1 to 0 SHALL preserve age order.

Reset
REQ-031 a_rst low SHALL asynchronously set head=0, tail=0, count=0, exe_valid=0, exe_uop=0, exe_slot=0; st_feed and sched_ack evaluate to 0.
REQ-032 Reset mid-operation SHALL discard any in-flight issue; stations are reset by the same a_rst.

Structure
REQ-033 Shared package holds NST, uOp field offsets of the 64-bit packing, and hazard-flag encodings.
REQ-034 One sub-module, station_hazard, SHALL compute the pairwise hazard bit for one (i, j) pair; instantiated NST*(NST-1) times.

Verification
REQ-035 Fill: 5 dec_valid cycles from reset -> st_feed 0001,0010,0100,1000; dec_ready=0 on cycle 5.
REQ-036 RAW: slot0 lock_wr=4'b1010, slot1 a_adr=3'b010 both ready -> slot0 issues first; slot1 ack only after slot0 complete.
REQ-037 Independent: slot0 not ready, slot1 ready, no hazards -> sched_ack=0010, exe_slot=1 next cycle.
REQ-038 Backpressure: exe_ready=0 for 3 cycles with exe_valid=1 -> exe_uop stable, sched_ack=0.
REQ-039 Wrap: head=3, tail=1, slot3 lock_loads=1, slot0 ld_mem ready -> slot0 blocked until slot3 retires.
REQ-040 Reset asserted during issue -> exe_valid=0, count=0 asynchronously, before next clock edge.
